// File: rtl/btn_conditioner.sv
// Button conditioner: per-button two-flop synchronizer, counter-based debounce FSM,
// registered clean level plus single-cycle press/release pulses in the pixel-clock domain.
module btn_conditioner #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_BTN-1:0] i_btn,
    output logic [NUM_BTN-1:0] o_level,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic               o_any_press
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CONF_PRESS = 2'd1,
        HELD       = 2'd2,
        CONF_REL   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync1_r;
    logic [NUM_BTN-1:0] sync2_r;
    state_t             state_r [NUM_BTN];
    state_t             state_s [NUM_BTN];
    logic [CNT_W-1:0]   cnt_r   [NUM_BTN];
    logic [CNT_W-1:0]   cnt_s   [NUM_BTN];
    logic [NUM_BTN-1:0] level_s;
    logic [NUM_BTN-1:0] press_s;
    logic [NUM_BTN-1:0] release_s;

    // Two-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= i_btn;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state logic; a counter only advances while the input disagrees with the level.
    always_comb begin
        level_s   = o_level;
        press_s   = '0;
        release_s = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            state_s[i] = state_r[i];
            cnt_s[i]   = cnt_r[i];
            case (state_r[i])
                IDLE: begin
                    if (sync2_r[i]) begin
                        state_s[i] = CONF_PRESS;
                        cnt_s[i]   = '0;
                    end else begin
                        state_s[i] = IDLE;
                    end
                end
                CONF_PRESS: begin
                    if (!sync2_r[i]) begin
                        state_s[i] = IDLE;
                    end else if (cnt_r[i] == CNT_LAST) begin
                        state_s[i] = HELD;
                        level_s[i] = 1'b1;
                        press_s[i] = 1'b1;
                    end else begin
                        cnt_s[i] = cnt_r[i] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!sync2_r[i]) begin
                        state_s[i] = CONF_REL;
                        cnt_s[i]   = '0;
                    end else begin
                        state_s[i] = HELD;
                    end
                end
                CONF_REL: begin
                    if (sync2_r[i]) begin
                        state_s[i] = HELD;
                    end else if (cnt_r[i] == CNT_LAST) begin
                        state_s[i]   = IDLE;
                        level_s[i]   = 1'b0;
                        release_s[i] = 1'b1;
                    end else begin
                        cnt_s[i] = cnt_r[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_s[i] = IDLE;
                    cnt_s[i]   = '0;
                    level_s[i] = 1'b0;
                end
            endcase
        end
    end

    // FSM state, counters and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_r[i] <= IDLE;
                cnt_r[i]   <= '0;
            end
            o_level     <= '0;
            o_press     <= '0;
            o_release   <= '0;
            o_any_press <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
            end
            o_level     <= level_s;
            o_press     <= press_s;
            o_release   <= release_s;
            o_any_press <= |press_s;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with a short debounce: latency and reset sequences, a
// vector table, and random toggling checked against a stable-run-length reference model.
module tb_btn_conditioner;

    localparam int NB = 5;
    localparam int DC = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [NB-1:0] o_level, o_press, o_release;
    logic          o_any_press;

    btn_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_btn       (btn),
        .o_level     (o_level),
        .o_press     (o_press),
        .o_release   (o_release),
        .o_any_press (o_any_press)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int press_cnt;
    int rel_cnt;

    // Reference: an input change is accepted once the synchronized value has
    // disagreed with the level for DC+1 consecutive edges.
    logic [NB-1:0] m_level, m_press, m_rel, d1, d2;
    int            run [NB];

    typedef struct {
        logic [NB-1:0] btn;
        int            cycles;
        logic [NB-1:0] exp_level;
        int            exp_press;
        int            exp_rel;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = '0; m_press = '0; m_rel = '0; d1 = '0; d2 = '0;
        for (int i = 0; i < NB; i++) run[i] = 0;
    endtask

    task automatic model_edge(input logic [NB-1:0] b);
        m_press = '0;
        m_rel   = '0;
        for (int i = 0; i < NB; i++) begin
            if (d2[i] != m_level[i]) begin
                run[i]++;
                if (run[i] == DC + 1) begin
                    if (m_level[i]) m_rel[i] = 1'b1;
                    else            m_press[i] = 1'b1;
                    m_level[i] = ~m_level[i];
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        d2 = d1;
        d1 = b;
    endtask

    task automatic step(input string name);
        @(posedge clk);
        model_edge(btn);
        #1;
        check(name, {o_level, o_press, o_release, o_any_press},
              {m_level, m_press, m_rel, |m_press});
        press_cnt += $countones(o_press);
        rel_cnt   += $countones(o_release);
    endtask

    initial begin
        vecs.push_back('{5'b00001,   20, 5'b00001, 0, 0});
        vecs.push_back('{5'b00101,    3, 5'b00001, 0, 0});
        vecs.push_back('{5'b00001,   10, 5'b00001, 0, 0});
        vecs.push_back('{5'b00011,   20, 5'b00011, 1, 0});
        vecs.push_back('{5'b00001,   20, 5'b00001, 0, 1});
        vecs.push_back('{5'b00000,    1, 5'b00001, 0, 0});
        vecs.push_back('{5'b00001,    1, 5'b00001, 0, 0});
        vecs.push_back('{5'b00000,    1, 5'b00001, 0, 0});
        vecs.push_back('{5'b00001,   12, 5'b00001, 0, 0});
        vecs.push_back('{5'b00000,   20, 5'b00000, 0, 1});
        vecs.push_back('{5'b01111,   20, 5'b01111, 4, 0});
        vecs.push_back('{5'b00000,   20, 5'b00000, 0, 4});
        vecs.push_back('{5'b01000, 1000, 5'b01000, 1, 0});
        vecs.push_back('{5'b00000,   20, 5'b00000, 0, 1});

        model_reset();
        press_cnt = 0;
        rel_cnt   = 0;
        @(posedge clk);
        #1;
        check("reset_state", {o_level, o_press, o_release, o_any_press}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean press latency: edge 0 is the first edge sampling the press.
        btn = 5'b00001;
        for (int e = 0; e <= 7; e++) begin
            step("lat_model");
            check("lat_press", {27'd0, o_press}, (e == 6) ? 32'd1 : 32'd0);
            check("lat_level", {27'd0, o_level}, (e >= 6) ? 32'd1 : 32'd0);
            check("lat_any", {31'd0, o_any_press}, (e == 6) ? 32'd1 : 32'd0);
        end

        foreach (vecs[v]) begin
            btn = vecs[v].btn;
            press_cnt = 0;
            rel_cnt = 0;
            for (int c = 0; c < vecs[v].cycles; c++) step("vec_model");
            check($sformatf("vec%0d_level", v), {27'd0, o_level}, {27'd0, vecs[v].exp_level});
            check($sformatf("vec%0d_npress", v), press_cnt, vecs[v].exp_press);
            check($sformatf("vec%0d_nrel", v), rel_cnt, vecs[v].exp_rel);
        end

        // Asynchronous reset while bit 4 is held, then re-qualification.
        btn = 5'b10000;
        for (int c = 0; c < 20; c++) step("hold4_model");
        check("hold4_level", {27'd0, o_level}, 32'h10);
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_async", {o_level, o_press, o_release, o_any_press}, 16'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rel_cnt = 0;
        for (int e = 0; e <= 7; e++) begin
            step("requal_model");
            check("requal_press", {27'd0, o_press}, (e == 6) ? 32'h10 : 32'h0);
        end
        check("requal_norel", rel_cnt, 0);

        // Random toggling.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
            step("rand_model");
        end
        btn = '0;
        for (int c = 0; c < 20; c++) step("drain_model");
        check("drain_level", {27'd0, o_level}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the five raw board push-buttons (up, right, down, left, game-reset) before they reach the VGA/game controller.
- Per button: a two-flop synchronizer, a counter-based debounce state machine, a clean level output, and single-cycle press and release pulses.
- Runs in the pixel-clock domain, so its outputs feed the game logic directly with no further crossing.
- One instance sits between the top-level button pins and the game/VGA block.

Parameters:
- NUM_BTN, 5, number of buttons handled. Bit order: 0=up, 1=right, 2=down, 3=left, 4=rst.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a change (10 ms at 25 MHz). Legal minimum is 2.
- CNT_W, 18, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- i_clk  in  1  pixel clock.
- i_rst  in  1  asynchronous active-low reset.
- i_btn  in  NUM_BTN  raw asynchronous button levels, 1 = pressed.
- o_level  out  NUM_BTN  debounced level, 1 = held.
- o_press  out  NUM_BTN  one-cycle pulse on an accepted press.
- o_release  out  NUM_BTN  one-cycle pulse on an accepted release.
- o_any_press  out  1  OR of o_press, registered in the same cycle as o_press.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - Clears all synchronizer flops, counters and outputs to 0.
  - Every FSM goes to IDLE.
  - Reset deasserts synchronously at a rising edge of i_clk.
- Synchronizer:
  - Two flops per bit: s1 <= i_btn, s2 <= s1.
  - The FSM sees only s2.
- Per-button FSM states: IDLE, CONF_PRESS, HELD, CONF_REL.
  - IDLE: if s2=1, go to CONF_PRESS and set cnt=0.
  - CONF_PRESS:
    - s2=0: go to IDLE (glitch rejected, no pulse).
    - Else, if cnt==DEBOUNCE_CYCLES-1: go to HELD, set o_level=1, pulse o_press for one cycle.
    - Else: cnt++.
  - HELD: if s2=0, go to CONF_REL and set cnt=0.
  - CONF_REL:
    - s2=1: go to HELD (bounce rejected, no pulse).
    - Else, if cnt==DEBOUNCE_CYCLES-1: go to IDLE, set o_level=0, pulse o_release for one cycle.
    - Else: cnt++.
- Latency:
  - Take edge 0 as the first rising edge that samples i_btn=1.
  - With i_btn held steady, o_press and o_level go high after edge DEBOUNCE_CYCLES+2.
  - o_press returns low after the next edge.
  - Release is symmetric.
- Pulse rules:
  - o_press and o_release are never high together for the same bit.
  - Each accepted transition produces exactly one pulse.
  - A held button never re-pulses.
- Counter: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Independence: buttons are fully independent. Simultaneous presses on several bits pulse in the same cycle, and o_any_press=1 for that one cycle only.
- All outputs are registered, with no combinational path from i_btn.
- Reset mid-operation: asserting i_rst while in HELD or CONF_* drops o_level immediately with no o_release pulse. If the button is still held after reset, it must be re-qualified from IDLE.

Test Plan (all scenarios use DEBOUNCE_CYCLES=4):
- Clean press: i_btn[0]=1 at edge 0, held 20 cycles -> o_level[0]=1 and o_press[0]=1 after edge 6; o_press[0]=0 after edge 7; o_any_press mirrors o_press; other bits stay 0.
- Glitch rejection: i_btn[2] high for 3 cycles, then low -> no o_press[2], o_level[2] stays 0. Repeat with bounce 1-0-1-0 during release -> o_level stays 1, no o_release.
- Release: from HELD, i_btn[1]=0 at edge 0 -> o_level[1]=0 and o_release[1]=1 after edge 6, single cycle.
- Simultaneous: i_btn=5'b01111 at the same edge -> o_press=5'b01111 for exactly one cycle, o_any_press=1 for exactly one cycle.
- Long hold: i_btn[3] held 1000 cycles -> exactly one o_press[3] pulse, o_level[3]=1 throughout after qualification.
- Async reset mid-hold: i_rst=0 between clock edges while o_level[4]=1 -> all outputs 0 before the next edge, no o_release. Release reset with i_btn[4] still 1 -> new o_press[4] after 6 edges.
